// File: rtl/lcd_spi_responder_if.sv
// lcd_spi_responder_if: 4-wire ST7789 serial link pins between host driver and display responder
interface lcd_spi_responder_if;
    logic lcd_rst;
    logic lcd_rs;
    logic lcd_sd;
    logic lcd_scl;
    logic lcd_cs;
    modport master (output lcd_rst, lcd_rs, lcd_sd, lcd_scl, lcd_cs);
    modport slave  (input  lcd_rst, lcd_rs, lcd_sd, lcd_scl, lcd_cs);
endinterface

// File: rtl/lcd_spi_responder.sv
// lcd_spi_responder: oversampling ST7789 serial endpoint decoding commands and RGB565 pixel writes
module lcd_spi_responder #(
    parameter int H_RES = 240,
    parameter int V_RES = 280
) (
    input  logic               clk,
    input  logic               rst,
    lcd_spi_responder_if.slave lcd,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               pix_valid,
    output logic [8:0]         pix_x,
    output logic [8:0]         pix_y,
    output logic [15:0]        pix_data,
    output logic               sleep_out,
    output logic               disp_on,
    output logic [7:0]         colmod,
    output logic               err_fmt
);
    typedef enum logic [1:0] {IDLE, PARAM, RAMWR_HI, RAMWR_LO} state_t;
    localparam logic [15:0] H_LIM = 16'(H_RES);
    localparam logic [15:0] V_LIM = 16'(V_RES);
    state_t state, state_n;
    logic [4:0] s1, s2;
    logic scl_d, scl_rise, sd_r, rs_r, cs_r;
    logic [2:0] cnt, pidx;
    logic [6:0] shr;
    logic [23:0] shd;
    logic [7:0] hi, byte_w;
    logic [15:0] xs, xe, ys, ye, x, y;
    logic p_rst, smp, byte_done, is_cmd, is_dat, panel_rst, fmt_ok;
    assign p_rst     = ~s2[4];
    assign smp       = scl_rise & ~cs_r;
    assign byte_done = smp & (cnt == 3'd7);
    assign byte_w    = {shr, sd_r};
    assign is_cmd    = byte_done & ~rs_r;
    assign is_dat    = byte_done & rs_r;
    assign panel_rst = p_rst | (is_cmd & (byte_w == 8'h01));
    assign fmt_ok    = colmod == 8'h55;
    // two-flop synchronisers {rst,rs,sd,scl,cs} then a registered SCL rise with its sd/rs/cs sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1       <= 5'b00011;
            s2       <= 5'b00011;
            scl_d    <= 1'b1;
            scl_rise <= 1'b0;
            sd_r     <= 1'b0;
            rs_r     <= 1'b0;
            cs_r     <= 1'b1;
        end else begin
            s1       <= {lcd.lcd_rst, lcd.lcd_rs, lcd.lcd_sd, lcd.lcd_scl, lcd.lcd_cs};
            s2       <= s1;
            scl_d    <= s2[1];
            scl_rise <= s2[1] & ~scl_d;
            sd_r     <= s2[2];
            rs_r     <= s2[3];
            cs_r     <= s2[0];
        end
    end
    // bit counter and shifter; cs high or panel reset drops any partial byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 3'd0;
            shr <= 7'd0;
        end else if (p_rst | cs_r) begin
            cnt <= 3'd0;
        end else if (smp) begin
            cnt <= cnt + 3'd1;
            shr <= {shr[5:0], sd_r};
        end
    end
    // decoder state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end
    // next decoder state: commands pick the context, data bytes alternate pixel halves
    always_comb begin
        state_n = state;
        if (is_cmd)
            state_n = (byte_w == 8'h2A || byte_w == 8'h2B || byte_w == 8'h3A) ? PARAM :
                      (byte_w == 8'h2C) ? RAMWR_HI : IDLE;
        else if (is_dat)
            state_n = (state == RAMWR_HI) ? RAMWR_LO : (state == RAMWR_LO) ? RAMWR_HI : state;
        if (p_rst) state_n = IDLE;
    end
    // command effects, window shadow/commit, pixel emission and address advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            pix_valid <= 1'b0;
            pix_x     <= 9'd0;
            pix_y     <= 9'd0;
            pix_data  <= 16'h0000;
            sleep_out <= 1'b0;
            disp_on   <= 1'b0;
            colmod    <= 8'h66;
            err_fmt   <= 1'b0;
            pidx      <= 3'd0;
            shd       <= 24'd0;
            hi        <= 8'h00;
            xs        <= 16'd0;
            ys        <= 16'd0;
            xe        <= H_LIM - 16'd1;
            ye        <= V_LIM - 16'd1;
            x         <= 16'd0;
            y         <= 16'd0;
        end else begin
            cmd_valid <= 1'b0;
            pix_valid <= 1'b0;
            if (is_cmd) begin
                cmd_valid <= 1'b1;
                cmd_code  <= byte_w;
                pidx      <= 3'd0;
                if (byte_w == 8'h11) sleep_out <= 1'b1;
                if (byte_w == 8'h10) sleep_out <= 1'b0;
                if (byte_w == 8'h29) disp_on <= 1'b1;
                if (byte_w == 8'h28) disp_on <= 1'b0;
                if (byte_w == 8'h2C) begin
                    x <= xs;
                    y <= ys;
                end
            end
            if (is_dat && state == PARAM && pidx != 3'd4) begin
                pidx <= pidx + 3'd1;
                shd  <= {shd[15:0], byte_w};
                if (cmd_code == 8'h3A && pidx == 3'd0) colmod <= byte_w;
                if (cmd_code == 8'h2A && pidx == 3'd3) begin
                    xs <= shd[23:8];
                    xe <= {shd[7:0], byte_w};
                end
                if (cmd_code == 8'h2B && pidx == 3'd3) begin
                    ys <= shd[23:8];
                    ye <= {shd[7:0], byte_w};
                end
            end
            if (is_dat && state == RAMWR_HI) begin
                hi <= byte_w;
                if (!fmt_ok) err_fmt <= 1'b1;
            end
            if (is_dat && state == RAMWR_LO) begin
                if (fmt_ok) begin
                    pix_valid <= (x < H_LIM) && (y < V_LIM);
                    pix_x     <= x[8:0];
                    pix_y     <= y[8:0];
                    pix_data  <= {hi, byte_w};
                end else begin
                    err_fmt <= 1'b1;
                end
                x <= (x >= xe) ? xs : x + 16'd1;
                y <= (x >= xe) ? ((y >= ye) ? ys : y + 16'd1) : y;
            end
            if (panel_rst) begin
                xs        <= 16'd0;
                ys        <= 16'd0;
                xe        <= H_LIM - 16'd1;
                ye        <= V_LIM - 16'd1;
                colmod    <= 8'h66;
                sleep_out <= 1'b0;
                disp_on   <= 1'b0;
                pidx      <= 3'd0;
            end
        end
    end
endmodule

// File: tb/tb_lcd_spi_responder.sv
// tb_lcd_spi_responder: drives the serial link and checks decoded commands/pixels against a window model
module tb_lcd_spi_responder;
    localparam int H = 240;
    localparam int V = 280;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    lcd_spi_responder_if lcd();
    logic        cmd_valid, pix_valid, sleep_out, disp_on, err_fmt;
    logic [7:0]  cmd_code, colmod;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_data;
    lcd_spi_responder #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst(rst), .lcd(lcd.slave),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .sleep_out(sleep_out), .disp_on(disp_on), .colmod(colmod), .err_fmt(err_fmt)
    );
    int total = 0;
    int bad = 0;
    logic [7:0]  got_cmd[$];
    logic [33:0] got_pix[$];
    logic [33:0] exp_pix[$];
    logic [15:0] px_q[$];
    logic [15:0] m_xs, m_xe, m_ys, m_ye;
    logic [7:0]  m_colmod;
    logic        cv_d = 1'b0;
    logic        pv_d = 1'b0;
    // capture pulses and check they are single-cycle and never coincide
    always @(negedge clk) begin
        if (cmd_valid) got_cmd.push_back(cmd_code);
        if (pix_valid) got_pix.push_back({pix_x, pix_y, pix_data});
        if (cmd_valid || pix_valid) begin
            total++;
            if ((cmd_valid && pix_valid) || (cmd_valid && cv_d) || (pix_valid && pv_d)) begin
                bad++;
                $display("FAIL pulse_shape cmd_valid=%0b pix_valid=%0b prev=%0b%0b required single 1-clk exclusive pulses",
                         cmd_valid, pix_valid, cv_d, pv_d);
            end
        end
        cv_d = cmd_valid;
        pv_d = pix_valid;
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send_byte(input logic r, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            lcd.lcd_rs  = r;
            lcd.lcd_sd  = b[i];
            lcd.lcd_scl = 1'b0;
            tick(4);
            lcd.lcd_scl = 1'b1;
            tick(4);
        end
    endtask
    task automatic end_cs();
        lcd.lcd_scl = 1'b0;
        tick(4);
        lcd.lcd_cs = 1'b1;
        tick(8);
    endtask
    task automatic xfer(input logic [7:0] c, input int n, input logic [7:0] p0 = 0, input logic [7:0] p1 = 0,
                        input logic [7:0] p2 = 0, input logic [7:0] p3 = 0);
        lcd.lcd_cs = 1'b0;
        tick(2);
        send_byte(1'b0, c);
        for (int i = 0; i < n; i++) send_byte(1'b1, i == 0 ? p0 : i == 1 ? p1 : i == 2 ? p2 : p3);
        end_cs();
    endtask
    task automatic m_reset();
        m_xs = 16'd0;
        m_ys = 16'd0;
        m_xe = 16'(H - 1);
        m_ye = 16'(V - 1);
        m_colmod = 8'h66;
    endtask
    task automatic panel_reset();
        lcd.lcd_rst = 1'b0;
        tick(4);
        lcd.lcd_rst = 1'b1;
        tick(4);
        m_reset();
    endtask
    task automatic set_win(input logic [15:0] xs, input logic [15:0] xe, input logic [15:0] ys, input logic [15:0] ye);
        xfer(8'h2A, 4, xs[15:8], xs[7:0], xe[15:8], xe[7:0]);
        xfer(8'h2B, 4, ys[15:8], ys[7:0], ye[15:8], ye[7:0]);
        m_xs = xs;
        m_xe = xe;
        m_ys = ys;
        m_ye = ye;
    endtask
    // pixel i of a RAMWR lands at column xs + i mod width, row ys + (i div width) mod height
    task automatic ramwr();
        int w, h, cx, cy;
        w = int'(m_xe) - int'(m_xs) + 1;
        h = int'(m_ye) - int'(m_ys) + 1;
        exp_pix.delete();
        foreach (px_q[i]) begin
            cx = int'(m_xs) + i % w;
            cy = int'(m_ys) + (i / w) % h;
            if (m_colmod == 8'h55 && cx < H && cy < V) exp_pix.push_back({9'(cx), 9'(cy), px_q[i]});
        end
        got_pix.delete();
        lcd.lcd_cs = 1'b0;
        tick(2);
        send_byte(1'b0, 8'h2C);
        foreach (px_q[i]) begin
            send_byte(1'b1, px_q[i][15:8]);
            send_byte(1'b1, px_q[i][7:0]);
        end
        end_cs();
    endtask
    task automatic test_reset();
        lcd.lcd_rst = 1'b1;
        lcd.lcd_cs  = 1'b1;
        lcd.lcd_scl = 1'b0;
        lcd.lcd_sd  = 1'b0;
        lcd.lcd_rs  = 1'b0;
        m_reset();
        tick(3);
        total++;
        if ({cmd_valid, pix_valid, sleep_out, disp_on, err_fmt} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000", {cmd_valid, pix_valid, sleep_out, disp_on, err_fmt});
        end
        total++;
        if ({cmd_code, pix_x, pix_y, pix_data} !== 42'd0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {cmd_code, pix_x, pix_y, pix_data});
        end
        total++;
        if (colmod !== 8'h66) begin
            bad++;
            $display("FAIL reset_colmod got=%h exp=66", colmod);
        end
        rst = 1'b1;
        tick(8);
        total++;
        if (got_cmd.size() !== 0 || colmod !== 8'h66) begin
            bad++;
            $display("FAIL post_reset cmds=%0d colmod=%h exp 0 cmds colmod=66", got_cmd.size(), colmod);
        end
    endtask
    task automatic test_status();
        got_cmd.delete();
        xfer(8'h11, 0);
        xfer(8'h3A, 1, 8'h55);
        xfer(8'h29, 0);
        m_colmod = 8'h55;
        total++;
        if (got_cmd.size() !== 3) begin
            bad++;
            $display("FAIL status_count got=%0d exp=3", got_cmd.size());
        end else begin
            total++;
            if ({got_cmd[0], got_cmd[1], got_cmd[2]} !== 24'h113A29) begin
                bad++;
                $display("FAIL status_codes got=%h%h%h exp=113a29", got_cmd[0], got_cmd[1], got_cmd[2]);
            end
        end
        total++;
        if ({sleep_out, disp_on, colmod} !== {2'b11, 8'h55}) begin
            bad++;
            $display("FAIL status_flags got=%b%b/%h exp=11/55", sleep_out, disp_on, colmod);
        end
    endtask
    task automatic test_latency();
        int lat = 0;
        lcd.lcd_cs = 1'b0;
        tick(2);
        for (int i = 7; i >= 1; i--) begin
            lcd.lcd_rs  = 1'b0;
            lcd.lcd_sd  = 1'b0;
            lcd.lcd_scl = 1'b0;
            tick(4);
            lcd.lcd_scl = 1'b1;
            tick(4);
        end
        lcd.lcd_scl = 1'b0;
        tick(4);
        lcd.lcd_scl = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (cmd_valid && lat == 0) lat = i;
        end
        end_cs();
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL cmd_latency got=%0d exp=4 clk", lat);
        end
    endtask
    task automatic test_window();
        set_win(16'd10, 16'd11, 16'd20, 16'd21);
        px_q = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F};
        ramwr();
        total++;
        if (got_pix.size() !== exp_pix.size()) begin
            bad++;
            $display("FAIL window_count got=%0d exp=%0d", got_pix.size(), exp_pix.size());
        end else foreach (exp_pix[i]) begin
            total++;
            if (got_pix[i] !== exp_pix[i]) begin
                bad++;
                $display("FAIL window_pix%0d got=%h exp=%h", i, got_pix[i], exp_pix[i]);
            end
        end
    endtask
    task automatic test_clip();
        set_win(16'd238, 16'd241, m_ys, m_ye);
        px_q.delete();
        for (int i = 0; i < 5; i++) px_q.push_back(16'($urandom));
        ramwr();
        total++;
        if (got_pix.size() !== 3 || exp_pix.size() !== 3) begin
            bad++;
            $display("FAIL clip_count got=%0d exp=3", got_pix.size());
        end else foreach (exp_pix[i]) begin
            total++;
            if (got_pix[i] !== exp_pix[i]) begin
                bad++;
                $display("FAIL clip_pix%0d got=%h exp=%h", i, got_pix[i], exp_pix[i]);
            end
        end
    endtask
    task automatic test_cs_abort();
        xfer(8'h28, 0);
        total++;
        if (disp_on !== 1'b0) begin
            bad++;
            $display("FAIL dispoff got=%b exp=0", disp_on);
        end
        got_cmd.delete();
        lcd.lcd_cs = 1'b0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            lcd.lcd_rs  = 1'b0;
            lcd.lcd_sd  = 1'b1;
            lcd.lcd_scl = 1'b0;
            tick(4);
            lcd.lcd_scl = 1'b1;
            tick(4);
        end
        end_cs();
        xfer(8'h29, 0);
        total++;
        if (got_cmd.size() !== 1 || cmd_code !== 8'h29 || disp_on !== 1'b1) begin
            bad++;
            $display("FAIL cs_abort cmds=%0d code=%h disp=%b exp 1/29/1", got_cmd.size(), cmd_code, disp_on);
        end
    endtask
    task automatic test_partial_caset();
        panel_reset();
        xfer(8'h3A, 1, 8'h55);
        m_colmod = 8'h55;
        xfer(8'h2A, 2, 8'h00, 8'h05);
        px_q = {16'($urandom), 16'($urandom)};
        ramwr();
        total++;
        if (got_pix.size() !== 2 || got_pix[0][33:16] !== 18'd0) begin
            bad++;
            $display("FAIL partial_first n=%0d got=%h exp=(0,0)", got_pix.size(), got_pix.size() > 0 ? got_pix[0] : 34'd0);
        end else foreach (exp_pix[i]) begin
            total++;
            if (got_pix[i] !== exp_pix[i]) begin
                bad++;
                $display("FAIL partial_pix%0d got=%h exp=%h", i, got_pix[i], exp_pix[i]);
            end
        end
    endtask
    task automatic test_random();
        logic [15:0] xs, ys;
        for (int k = 0; k < 4; k++) begin
            xs = 16'($urandom_range(0, 250));
            ys = 16'($urandom_range(0, 285));
            set_win(xs, xs + 16'($urandom_range(0, 3)), ys, ys + 16'($urandom_range(0, 2)));
            px_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) px_q.push_back(16'($urandom));
            ramwr();
            total++;
            if (got_pix.size() !== exp_pix.size()) begin
                bad++;
                $display("FAIL random%0d_count got=%0d exp=%0d", k, got_pix.size(), exp_pix.size());
            end else foreach (exp_pix[i]) begin
                total++;
                if (got_pix[i] !== exp_pix[i]) begin
                    bad++;
                    $display("FAIL random%0d_pix%0d got=%h exp=%h", k, i, got_pix[i], exp_pix[i]);
                end
            end
        end
    endtask
    task automatic test_rst_mid();
        xfer(8'h11, 0);
        got_cmd.delete();
        lcd.lcd_cs = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            lcd.lcd_rs  = 1'b0;
            lcd.lcd_sd  = 1'b1;
            lcd.lcd_scl = 1'b0;
            tick(4);
            lcd.lcd_scl = 1'b1;
            tick(4);
        end
        rst = 1'b0;
        tick(2);
        total++;
        if ({sleep_out, colmod, cmd_code, cmd_valid, pix_valid} !== {1'b0, 8'h66, 8'h00, 2'b00}) begin
            bad++;
            $display("FAIL rst_mid got=%b/%h/%h exp=0/66/00", sleep_out, colmod, cmd_code);
        end
        rst = 1'b1;
        end_cs();
        m_reset();
        total++;
        if (got_cmd.size() !== 0) begin
            bad++;
            $display("FAIL rst_mid_stray got=%0d exp=0", got_cmd.size());
        end
    endtask
    task automatic test_fmt_err();
        panel_reset();
        xfer(8'h11, 0);
        px_q = {16'hA55A};
        ramwr();
        total++;
        if (got_pix.size() !== 0 || err_fmt !== 1'b1) begin
            bad++;
            $display("FAIL fmt_err pix=%0d err=%b exp 0/1", got_pix.size(), err_fmt);
        end
        panel_reset();
        total++;
        if ({colmod, sleep_out, err_fmt} !== {8'h66, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL fmt_after_rst got=%h/%b/%b exp=66/0/1", colmod, sleep_out, err_fmt);
        end
    endtask
    initial begin
        test_reset();
        test_status();
        test_latency();
        test_window();
        test_clip();
        test_cs_abort();
        test_partial_caset();
        test_random();
        test_rst_mid();
        test_fmt_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
